asdp_mem: RTL and testbench

- Simple dual-port RAM with one synchronous write port (A) and one asynchronous, combinational read port (B).
- Port A writes on the rising edge of clka. Port B returns the word at addrb with no clock latency.
- Used as a LUT/distributed-RAM style storage element, for example in register files, small FIFOs and lookup tables, inside the single clka domain.

---
 rtl/asdp_mem_pkg.sv | 8 +
 rtl/asdp_mem.sv | 41 ++++
 tb/tb_asdp_mem.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/asdp_mem_pkg.sv
// Shared defaults for the asdp_mem simple dual-port RAM.
package asdp_mem_pkg;

  // Default geometry: 64 words of 32 bits.
  localparam int unsigned ASDP_DEPTH_DEF = 6;
  localparam int unsigned ASDP_WIDTH_DEF = 32;

endpackage : asdp_mem_pkg

// File: rtl/asdp_mem.sv
// asdp_mem: simple dual-port RAM, synchronous write port A, combinational
// read port B. Written so synthesis maps it onto distributed/LUT RAM.
module asdp_mem
  import asdp_mem_pkg::*;
#(
  parameter int unsigned DEPTH = ASDP_DEPTH_DEF,  // address width in bits
  parameter int unsigned WIDTH = ASDP_WIDTH_DEF   // data word width in bits
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             ena,
  input  logic             wea,
  input  logic [DEPTH-1:0] addra,
  input  logic [WIDTH-1:0] dia,
  input  logic [DEPTH-1:0] addrb,
  output logic [WIDTH-1:0] dob
);

  localparam int unsigned WORDS = 2 ** DEPTH;

  logic [WIDTH-1:0] mem_q [WORDS];

  logic write_en;

  // A write needs the port enabled, the write strobe, and no reset in progress.
  assign write_en = ena & wea & ~rst;

  // Port A write; reset only inhibits the write and never touches contents.
  // NOTE: the array is deliberately left out of reset -- a per-word clear
  // loop would stop the tools from inferring LUT RAM.
  always_ff @(posedge clka) begin
    if (write_en) begin
      mem_q[addra] <= dia;
    end
  end

  // Port B read is pure combinational decode of addrb, so a same-address
  // write becomes visible right after the clock edge that performs it.
  assign dob = mem_q[addrb];

endmodule : asdp_mem

// File: tb/tb_asdp_mem.sv
// Self-checking bench for asdp_mem: expected words are queued when stimulus
// is driven and compared when port B is read back.
module tb_asdp_mem;

  localparam int unsigned DEPTH = 6;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned WORDS = 2 ** DEPTH;

  logic             clka;
  logic             rst;
  logic             ena;
  logic             wea;
  logic [DEPTH-1:0] addra;
  logic [WIDTH-1:0] dia;
  logic [DEPTH-1:0] addrb;
  logic [WIDTH-1:0] dob;

  typedef struct {
    string            tag;
    logic [DEPTH-1:0] addr;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sb_q[$];

  int checks_cnt;
  int errors_cnt;

  asdp_mem #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .clka (clka),
    .rst  (rst),
    .ena  (ena),
    .wea  (wea),
    .addra(addra),
    .dia  (dia),
    .addrb(addrb),
    .dob  (dob)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive port A for exactly one rising edge, then return 1 ns after it.
  task automatic drive_edge(input logic r, input logic e, input logic w,
                            input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clka);
    rst   = r;
    ena   = e;
    wea   = w;
    addra = a;
    dia   = d;
    @(posedge clka);
    #1;
    rst = 1'b0;
    ena = 1'b0;
    wea = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [DEPTH-1:0] a,
                             input logic [WIDTH-1:0] d);
    exp_t e;
    e.tag  = tag;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Pop every queued expectation, present its address on port B and compare
  // after a small combinational settle (no clock edge in between).
  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      addrb = e.addr;
      #1;
      check(e.tag, dob, e.data);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] pattern;
    checks_cnt = 0;
    errors_cnt = 0;
    rst   = 1'b1;
    ena   = 1'b0;
    wea   = 1'b0;
    addra = '0;
    dia   = '0;
    addrb = 6'd1;

    // Cycle 1: reset.
    @(posedge clka);
    #1;
    rst = 1'b0;

    // Write then read: checked right after the writing edge, addrb already 1.
    drive_edge(1'b0, 1'b1, 1'b1, 6'd1, 32'h1122_3344);
    #1;
    check("wr_rd_a1_after_edge", dob, 32'h1122_3344);
    drive_edge(1'b0, 1'b1, 1'b1, 6'd2, 32'h5566_7788);
    expect_word("wr_rd_a2", 6'd2, 32'h5566_7788);
    expect_word("wr_rd_a1", 6'd1, 32'h1122_3344);
    drain();

    // Write inhibit: give address 0 a known prior value, then wea=0 edges.
    drive_edge(1'b0, 1'b1, 1'b1, 6'd0, 32'h0BAD_C0DE);
    for (int i = 0; i < 3; i++) drive_edge(1'b0, 1'b1, 1'b0, 6'd0, 32'h0);
    expect_word("inhibit_wea0", 6'd0, 32'h0BAD_C0DE);
    drive_edge(1'b0, 1'b0, 1'b1, 6'd1, 32'hDEAD_BEEF);
    expect_word("inhibit_ena0", 6'd1, 32'h1122_3344);
    drain();

    // Reset blocks a write; after deassertion the same write lands.
    drive_edge(1'b1, 1'b1, 1'b1, 6'd2, 32'hCAFE_F00D);
    expect_word("rst_blocks_write", 6'd2, 32'h5566_7788);
    drain();
    drive_edge(1'b0, 1'b1, 1'b1, 6'd2, 32'hCAFE_F00D);
    expect_word("write_after_rst", 6'd2, 32'hCAFE_F00D);
    drain();

    // Collision: addrb held on 3 while address 3 is rewritten.
    drive_edge(1'b0, 1'b1, 1'b1, 6'd3, 32'h3333_3333);
    addrb = 6'd3;
    @(negedge clka);
    rst   = 1'b0;
    ena   = 1'b1;
    wea   = 1'b1;
    addra = 6'd3;
    dia   = 32'hA5A5_A5A5;
    #1;
    check("collision_before_edge", dob, 32'h3333_3333);
    @(posedge clka);
    #1;
    ena = 1'b0;
    wea = 1'b0;
    check("collision_after_edge", dob, 32'hA5A5_A5A5);

    // Back-to-back writes to one address: the last one wins.
    drive_edge(1'b0, 1'b1, 1'b1, 6'd4, 32'h0000_0001);
    drive_edge(1'b0, 1'b1, 1'b1, 6'd4, 32'h0000_0002);
    expect_word("last_write_wins", 6'd4, 32'h0000_0002);
    drain();

    // Full range: every address gets addr ^ 0x5A5A5A5A, then a full sweep.
    for (int a = 0; a < WORDS; a++) begin
      pattern = 32'(a) ^ 32'h5A5A_5A5A;
      drive_edge(1'b0, 1'b1, 1'b1, DEPTH'(a), pattern);
      expect_word($sformatf("sweep_a%0d", a), DEPTH'(a), pattern);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule : tb_asdp_mem
